// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared constants, field slices and state encoding for the ID/EX skid stage
package id_ex_pkg;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int REG_W = 5;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          PC_LINK_OFFSET   = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_skid_stage.sv
// rtl/id_ex_skid_stage.sv - elastic ID/EX pipeline register with 2-entry skid buffer and bubble statistics
module id_ex_skid_stage
    import id_ex_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(PC_RESET_DEFAULT),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] ext_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc8_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] ext_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PL_W = 5 * DATA_W;
    localparam logic [PL_W-1:0] BUBBLE = {DATA_W'(NOP), PC_RESET, {(3 * DATA_W){1'b0}}};

    state_t          state;
    logic [PL_W-1:0] main_pl;
    logic [PL_W-1:0] skid_pl;
    logic [PL_W-1:0] in_pl;
    logic [PL_W-1:0] head_pl;
    logic            in_fire;
    logic            out_fire;
    logic            bubble_inc;

    assign in_pl    = {instr_in, pc_in, rd1_in, rd2_in, ext_in};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // in_ready and out_valid are flops updated with the state, so ready never depends on out_ready
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_pl   <= BUBBLE;
            skid_pl   <= BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_pl   <= in_pl;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_pl <= in_pl;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end else if (in_fire) begin
                        skid_pl  <= in_pl;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_pl  <= skid_pl;
                        skid_pl  <= BUBBLE;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    main_pl   <= BUBBLE;
                    skid_pl   <= BUBBLE;
                end
            endcase
        end
    end

    // main may hold a stale payload after draining, so outputs are forced to bubble when empty
    assign head_pl = out_valid ? main_pl : BUBBLE;
    assign {instr_out, pc_out, rd1_out, rd2_out, ext_out} = head_pl;
    assign pc8_out = pc_out + DATA_W'(PC_LINK_OFFSET);
    assign rs_out  = instr_out[RS_HI:RS_LO];
    assign rt_out  = instr_out[RT_HI:RT_LO];
    assign rd_out  = instr_out[RD_HI:RD_LO];

    assign bubble_inc = ~out_valid;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .clr  (reset),
        .inc  (bubble_inc),
        .count(bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb/tb_id_ex_skid_stage.sv - self-checking bench for id_ex_skid_stage against a queue-based reference
module tb_id_ex_skid_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
    } pl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr_in = '0, pc_in = '0, rd1_in = '0, rd2_in = '0, ext_in = '0;

    logic        in_ready, out_valid;
    logic [31:0] instr_out, pc_out, pc8_out, rd1_out, rd2_out, ext_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [15:0] bubble_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_instr, s_pc, s_pc8, s_rd1, s_rd2, s_ext;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [3:0]  s_bubble_cnt;

    always #5 clk = ~clk;

    id_ex_skid_stage #(.DATA_W(32), .PC_RESET(32'h0000_3000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .ext_in(ext_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_out(instr_out), .pc_out(pc_out), .pc8_out(pc8_out),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .ext_out(ext_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_skid_stage #(.DATA_W(32), .PC_RESET(32'h0000_3000), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .ext_in(ext_in),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .instr_out(s_instr), .pc_out(s_pc), .pc8_out(s_pc8),
        .rd1_out(s_rd1), .rd2_out(s_rd2), .ext_out(s_ext),
        .rs_out(s_rs), .rt_out(s_rt), .rd_out(s_rd),
        .bubble_cnt(s_bubble_cnt)
    );

    pl_t         mdl_q[$];
    int unsigned mdl_bc;
    int unsigned mdl_bc4;
    int          n_checks = 0;
    int          n_fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input pl_t p);
        in_valid = v;
        instr_in = p.instr;
        pc_in    = p.pc;
        rd1_in   = p.rd1;
        rd2_in   = p.rd2;
        ext_in   = p.ext;
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p.instr = $urandom;
        p.pc    = $urandom;
        p.rd1   = $urandom;
        p.rd2   = $urandom;
        p.ext   = $urandom;
        return p;
    endfunction

    // Reference: a FIFO of capacity two; the head is whatever EX sees
    task automatic compare_all();
        pl_t h;
        bit  has = (mdl_q.size() != 0);
        h.instr = 32'h0;
        h.pc    = 32'h0000_3000;
        h.rd1   = 32'h0;
        h.rd2   = 32'h0;
        h.ext   = 32'h0;
        if (has) h = mdl_q[0];
        check("out_valid", 32'(out_valid), 32'(has));
        check("in_ready", 32'(in_ready), 32'(mdl_q.size() < 2));
        check("instr_out", instr_out, h.instr);
        check("pc_out", pc_out, h.pc);
        check("pc8_out", pc8_out, h.pc + 32'd8);
        check("rd1_out", rd1_out, h.rd1);
        check("rd2_out", rd2_out, h.rd2);
        check("ext_out", ext_out, h.ext);
        check("rs_out", 32'(rs_out), (h.instr / 32'h0020_0000) % 32);
        check("rt_out", 32'(rt_out), (h.instr / 32'h0001_0000) % 32);
        check("rd_out", 32'(rd_out), (h.instr / 32'h0000_0800) % 32);
        check("bubble_cnt", 32'(bubble_cnt), mdl_bc);
        check("bubble_cnt4", 32'(s_bubble_cnt), mdl_bc4);
    endtask

    task automatic cycle();
        bit   acc, pop;
        pl_t  inp;
        inp = {instr_in, pc_in, rd1_in, rd2_in, ext_in};
        acc = in_valid && (mdl_q.size() < 2);
        pop = out_ready && (mdl_q.size() != 0);
        if (reset) begin
            mdl_bc  = 0;
            mdl_bc4 = 0;
        end else if (mdl_q.size() == 0) begin
            if (mdl_bc < 65535) mdl_bc++;
            if (mdl_bc4 < 15) mdl_bc4++;
        end
        if (reset || flush) begin
            mdl_q.delete();
        end else begin
            if (pop) void'(mdl_q.pop_front());
            if (acc) mdl_q.push_back(inp);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        pl_t a, b, c;
        mdl_bc  = 0;
        mdl_bc4 = 0;
        #2;

        // reset state
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset_pc", pc_out, 32'h0000_3000);
        check("reset_pc8", pc8_out, 32'h0000_3008);

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a = rand_pl();
            a.instr = 32'h2408_0000 + 32'(i);
            drive(1'b1, a);
            cycle();
            check("stream_rt", 32'(rt_out), 32'd8);
        end
        drive(1'b0, a);
        cycle();

        // back-pressure fills the skid, then drains in order
        out_ready = 1'b0;
        a = rand_pl();
        b = rand_pl();
        drive(1'b1, a);
        cycle();
        drive(1'b1, b);
        cycle();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head_a", instr_out, a.instr);
        drive(1'b1, rand_pl());
        cycle();
        drive(1'b0, a);
        out_ready = 1'b1;
        cycle();
        check("bp_head_b", instr_out, b.instr);
        cycle();
        cycle();

        // flush while full with a concurrent offer
        out_ready = 1'b0;
        drive(1'b1, rand_pl());
        cycle();
        drive(1'b1, rand_pl());
        cycle();
        c = rand_pl();
        drive(1'b1, c);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, c);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_pc", pc_out, 32'h0000_3000);
        out_ready = 1'b1;
        cycle();
        cycle();

        // simultaneous accept and consume in ONE replaces the head
        out_ready = 1'b0;
        a = rand_pl();
        drive(1'b1, a);
        cycle();
        b = rand_pl();
        drive(1'b1, b);
        out_ready = 1'b1;
        cycle();
        check("swap_head", instr_out, b.instr);
        check("swap_ready", 32'(in_ready), 32'd1);

        // reset and flush together, mid-handshake
        out_ready = 1'b0;
        drive(1'b1, rand_pl());
        cycle();
        reset = 1'b1;
        flush = 1'b1;
        cycle();
        reset = 1'b0;
        flush = 1'b0;
        check("rst_flush_cnt", 32'(bubble_cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), rand_pl());
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;

        // idle long enough to saturate the narrow counter
        drive(1'b0, a);
        out_ready = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_cnt4", 32'(s_bubble_cnt), 32'd15);
        check("sat_cnt16", 32'(bubble_cnt), 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
